// File: rtl/result_checker.sv
// Result checker: compares words reported by a generated FSM test module against a
// preloaded expectation table and reports pass/fail, error count and first mismatch.
module result_checker #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             exp_wr,
   input  logic [AW-1:0]    exp_addr,
   input  logic [WIDTH-1:0] exp_data,
   input  logic             start,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             timed_out,
   output logic [CW-1:0]    err_count,
   output logic [AW-1:0]    first_bad
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] tbl [DEPTH];
   logic [AW-1:0]    idx;
   logic [TW-1:0]    timer;
   logic             xfer, last, expire, launch;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      xfer       = 1'b0;
      last       = 1'b0;
      expire     = 1'b0;
      launch     = 1'b0;
      case (state)
         IDLE, FIN: begin
            if (start) begin
               launch     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            xfer = in_valid;
            if (xfer && idx == AW'(DEPTH - 1)) begin
               last       = 1'b1;
               state_next = FIN;
            end else if (!xfer && timer == TW'(TIMEOUT - 1)) begin
               // the idle cycle that would bring timer to TIMEOUT ends the run
               expire     = 1'b1;
               state_next = FIN;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign in_ready = (state == RUN);
   assign busy     = (state == RUN);
   assign pass     = done && (err_count == '0) && !timed_out;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) tbl[i] <= '0;
         idx       <= '0;
         timer     <= '0;
         err_count <= '0;
         first_bad <= '0;
         timed_out <= 1'b0;
         done      <= 1'b0;
      end else begin
         if (state != RUN && exp_wr && 32'(exp_addr) < DEPTH)
            tbl[exp_addr] <= exp_data;
         if (launch) begin
            idx       <= '0;
            timer     <= '0;
            err_count <= '0;
            first_bad <= '0;
            timed_out <= 1'b0;
            done      <= 1'b0;
         end else if (state == RUN) begin
            if (xfer) begin
               if (in_data != tbl[idx]) begin
                  err_count <= err_count + 1'b1;
                  if (err_count == '0) first_bad <= idx;
               end
               idx   <= idx + 1'b1;
               timer <= '0;
               if (last) done <= 1'b1;
            end else begin
               timer <= timer + 1'b1;
               if (expire) begin
                  timed_out <= 1'b1;
                  done      <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_result_checker.sv
// Scoreboard bench for result_checker: stimulus queues expected run outcomes,
// a monitor checks them whenever done rises.
module tb_result_checker;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int TIMEOUT = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             exp_wr = 1'b0;
   logic [1:0]       exp_addr = '0;
   logic [WIDTH-1:0] exp_data = '0;
   logic             start = 1'b0;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_ready, busy, done, pass, timed_out;
   logic [2:0]       err_count;
   logic [1:0]       first_bad;

   result_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .exp_wr(exp_wr), .exp_addr(exp_addr), .exp_data(exp_data),
      .start(start), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .busy(busy), .done(done), .pass(pass), .timed_out(timed_out),
      .err_count(err_count), .first_bad(first_bad)
   );

   always #5 clk = ~clk;

   typedef struct {
      int errs;
      int fb;
      int tmo;
      int ok;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   rdy_cycles = 0;
   logic done_q = 1'b0;

   task automatic chk(input string name, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // monitor: one expected outcome per rising edge of done
   always @(negedge clk) begin
      if (in_ready) rdy_cycles++;
      if (done && !done_q) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("err_count", int'(err_count), e.errs);
            chk("timed_out", int'(timed_out), e.tmo);
            chk("pass", int'(pass), e.ok);
            chk("busy_at_done", int'(busy), 0);
            if (e.errs != 0) chk("first_bad", int'(first_bad), e.fb);
         end
      end
      done_q = done;
   end

   task automatic push(input int errs, input int fb, input int tmo, input int ok);
      exp_t e;
      e.errs = errs; e.fb = fb; e.tmo = tmo; e.ok = ok;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wr(input int a, input int d);
      exp_wr = 1'b1; exp_addr = 2'(a); exp_data = WIDTH'(d);
      tick();
      exp_wr = 1'b0;
   endtask

   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wr_go(input int a, input int d);
      exp_wr = 1'b1; exp_addr = 2'(a); exp_data = WIDTH'(d); start = 1'b1;
      tick();
      exp_wr = 1'b0; start = 1'b0;
   endtask

   task automatic send(input int w);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = WIDTH'(w);
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      if (n >= 40) chk("send_ready_timeout", 0, 1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 60) begin
         tick();
         n++;
      end
      if (n >= 60) chk("done_wait_timeout", 0, 1);
      tick();
   endtask

   initial begin
      int r0;
      int n;
      repeat (2) tick();
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err_count", int'(err_count), 0);
      reset = 1'b1;
      tick();

      // 1: all words match, back-to-back
      wr(0, 25); wr(1, 15); wr(2, 15); wr(3, 25);
      in_valid = 1'b1; in_data = 32'd7;
      tick();
      chk("idle_ignores_valid", int'(in_ready), 0);
      in_valid = 1'b0;
      push(0, 0, 0, 1);
      r0 = rdy_cycles;
      go();
      chk("busy_in_run", int'(busy), 1);
      send(25); send(15); send(15); send(25);
      wait_done();
      chk("ready_cycles", rdy_cycles - r0, 4);

      // 2: two mismatches, first at index 1
      push(2, 1, 0, 0);
      go();
      send(25); send(25); send(15); send(15);
      wait_done();

      // 3: timeout after two words
      push(0, 0, 1, 0);
      go();
      send(25); send(15);
      repeat (TIMEOUT - 1) tick();
      chk("no_early_timeout", int'(done), 0);
      tick();
      chk("timeout_done", int'(done), 1);
      wait_done();

      // 4: in_valid toggling, plus a start mid-run that must be ignored
      push(0, 0, 0, 1);
      go();
      send(25); tick(); send(15); tick();
      go();
      send(15); tick(); send(25);
      wait_done();

      // 5: write during run ignored; same write after done plus rerun mismatches word 0
      push(0, 0, 0, 1);
      go();
      wr(0, 99);
      send(25); send(15); send(15); send(25);
      wait_done();
      push(1, 0, 0, 0);
      wr_go(0, 99);
      send(25); send(15); send(15); send(25);
      wait_done();

      // 6: async reset mid-run
      go();
      send(25); send(15);
      @(negedge clk); #2;
      reset = 1'b0;
      #1;
      chk("arst_in_ready", int'(in_ready), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_err_count", int'(err_count), 0);
      chk("arst_first_bad", int'(first_bad), 0);
      chk("arst_done", int'(done), 0);
      chk("arst_pass", int'(pass), 0);
      tick();
      reset = 1'b1;
      tick();
      push(0, 0, 0, 1);
      go();
      send(0); send(0); send(0); send(0);
      wait_done();

      n = 0;
      while (q.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      chk("scoreboard_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
